// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and scan-state encoding for the 7-segment scan controller.
package seg7_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_scan_ctrl_bin_to_7seg.sv
// Combinational 4-bit to 7-segment decoder, segments {g,f,e,d,c,b,a} active-high.
// Codes 10..15 decode to all segments off.
module bin_to_7seg
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bin)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of 7-segment digits with a blank gap
// between digits and frame-aligned commit of new values.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 16,
  parameter bit AN_ACT_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid_i,
  output logic                      load_ready_o,
  input  logic [4*NUM_DIGITS-1:0]   value_i,
  input  logic                      lzb_i,
  output logic [6:0]                seg_o,
  output logic [NUM_DIGITS-1:0]     an_o,
  output logic                      frame_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRE_SHOW = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACT_LOW}};

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  scan_state_t             state, next_state;
  logic [4*NUM_DIGITS-1:0] active, pending;
  logic                    pending_flag;
  logic                    slot_end, frame_end, take;
  logic [3:0]              nib;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   sel;
  logic                    zero_run, blanked;

  assign slot_end     = (presc == PRE_LAST);
  assign frame_end    = slot_end && (idx == IDX_LAST);
  assign load_ready_o = ~pending_flag;
  assign take         = load_valid_i & ~pending_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      state <= ST_BLANK;
    end else begin
      state <= next_state;
      if (slot_end) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // State tracks the prescaler value of the cycle it is registered into.
  always_comb begin
    next_state = ST_BLANK;
    if (!slot_end && ((presc + PW'(1)) >= PRE_SHOW))
      next_state = ST_SHOW;
  end

  // A value parks in pending and is only promoted at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active       <= '0;
      pending      <= '0;
      pending_flag <= 1'b0;
    end else if (take) begin
      pending      <= value_i;
      pending_flag <= 1'b1;
    end else if (frame_end && pending_flag) begin
      active       <= pending;
      pending_flag <= 1'b0;
    end
  end

  // Walk from the top digit down so zero_run marks digits with only zeros at and above them.
  always_comb begin
    nib      = '0;
    sel      = '0;
    blanked  = 1'b0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (active[4*k +: 4] == 4'd0);
      if (idx == IW'(k)) begin
        nib     = active[4*k +: 4];
        sel[k]  = 1'b1;
        blanked = lzb_i && (k != 0) && zero_run;
      end
    end
  end

  bin_to_7seg u_dec (
    .bin (nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o   <= SEG_BLANK;
      an_o    <= AN_OFF;
      frame_o <= 1'b0;
    end else begin
      frame_o <= frame_end;
      if (state == ST_SHOW && !blanked) begin
        an_o  <= sel ^ AN_OFF;
        seg_o <= dec_seg;
      end else begin
        an_o  <= AN_OFF;
        seg_o <= SEG_BLANK;
      end
    end
  end

endmodule
